// File: rtl/ppe_sync.sv
// Clocked partial-sum PE: holds one filter row, slides it over a spike row, streams the sums to
// the SPEs round-robin and then requests the next row. Define PPE_SAT_EN for clamped sums.

module ppe_sync #(
    parameter int unsigned PE_ID        = 0,
    parameter int unsigned IMEM_ID      = 10,
    parameter int unsigned SPE_BASE     = 0,
    parameter int unsigned FILTER_SIZE  = 5,
    parameter int unsigned IFMAP_SIZE   = 25,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned SUM_WIDTH    = 14,
    parameter int unsigned NUM_ROWS     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [32:0] in_packet,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] out_packet,
    output logic        busy,
    output logic [3:0]  row_cnt
`ifdef PPE_SAT_EN
    ,
    output logic        sat_flag
`endif
);

    localparam int unsigned OutputDim = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int unsigned WVecW     = FILTER_SIZE * WEIGHT_WIDTH;

    typedef enum logic [1:0] {StIdle, StSum, StSend, StReq} state_e;

    state_e                  state_q, state_d;
    logic [WVecW-1:0]        weights_q, weights_d;
    logic [3:0]              wptr_q, wptr_d;
    logic [4:0]              j_q, j_d;
    logic [2:0]              dest_q, dest_d;
    logic [3:0]              row_cnt_q, row_cnt_d;
    logic [IFMAP_SIZE-1:0]   in_bits_q, in_bits_d;
    logic                    out_valid_q, out_valid_d;
    logic [32:0]             out_packet_q, out_packet_d;
    logic                    weight_we;
    logic [3:0]              opcode;
    logic                    unused_pkt;

    assign opcode     = in_packet[28:25];
    assign unused_pkt = ^in_packet[32:29];

    // Rebuild the weight vector slot by slot; a packet covers slots wptr..wptr+2.
    logic [WVecW-1:0]        w_rest, w_acc;
    logic [WEIGHT_WIDTH-1:0] w_slot;
    logic [3:0]              w_off;

    always_comb begin
        w_rest = weights_q;
        w_acc  = '0;
        w_slot = '0;
        w_off  = '0;
        for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
            w_slot = w_rest[WEIGHT_WIDTH-1:0];
            w_off  = 4'(i) - wptr_q;
            if (weight_we) begin
                case (w_off)
                    4'd0:    w_slot = in_packet[WEIGHT_WIDTH-1:0];
                    4'd1:    w_slot = in_packet[8 +: WEIGHT_WIDTH];
                    4'd2:    w_slot = in_packet[16 +: WEIGHT_WIDTH];
                    default: ;
                endcase
            end
            w_acc  = (w_acc >> WEIGHT_WIDTH) | (WVecW'(w_slot) << (WVecW - WEIGHT_WIDTH));
            w_rest = w_rest >> WEIGHT_WIDTH;
        end
        weights_d = w_acc;
    end

    logic [WVecW-1:0]               s_rest;
    logic [IFMAP_SIZE-1:0]          s_bits;
    logic signed [WEIGHT_WIDTH-1:0] s_w;
    logic signed [31:0]             acc;

    always_comb begin
        s_rest = weights_q;
        s_bits = in_bits_q >> j_q;
        s_w    = '0;
        acc    = '0;
        for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
            s_w = s_rest[WEIGHT_WIDTH-1:0];
            if (s_bits[0]) acc = acc + 32'(s_w);
            s_rest = s_rest >> WEIGHT_WIDTH;
            s_bits = s_bits >> 1;
        end
    end

    logic signed [SUM_WIDTH-1:0] sum_sw;
    logic [24:0]                 sum_ext;

`ifdef PPE_SAT_EN
    localparam int SumMax = (1 << (SUM_WIDTH - 1)) - 1;
    localparam int SumMin = -(1 << (SUM_WIDTH - 1));
    logic sat_hit, sat_q, sat_d;

    always_comb begin
        sat_hit = 1'b0;
        if (acc > SumMax) begin
            sum_sw  = SUM_WIDTH'(SumMax);
            sat_hit = 1'b1;
        end else if (acc < SumMin) begin
            sum_sw  = SUM_WIDTH'(SumMin);
            sat_hit = 1'b1;
        end else begin
            sum_sw = SUM_WIDTH'(acc);
        end
    end
    assign sat_flag = sat_q;
`else
    assign sum_sw = SUM_WIDTH'(acc);
`endif

    assign sum_ext = 25'(sum_sw);

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        j_d          = j_q;
        dest_d       = dest_q;
        row_cnt_d    = row_cnt_q;
        in_bits_d    = in_bits_q;
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        weight_we    = 1'b0;
`ifdef PPE_SAT_EN
        sat_d        = sat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    case (opcode)
                        4'd0: begin
                            weight_we = 1'b1;
                            wptr_d    = (32'(wptr_q) + 3 >= FILTER_SIZE) ? 4'd0 : wptr_q + 4'd3;
                        end
                        4'd1: begin
                            in_bits_d = in_packet[IFMAP_SIZE-1:0];
                            row_cnt_d = (row_cnt_q == 4'hF) ? row_cnt_q : row_cnt_q + 4'd1;
                            state_d   = StSum;
                        end
                        4'd15: begin
                            row_cnt_d = '0;
`ifdef PPE_SAT_EN
                            sat_d     = 1'b0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            StSum: begin
                out_packet_d = {4'(SPE_BASE + 32'(dest_q)), 4'd0, sum_ext};
                out_valid_d  = 1'b1;
                state_d      = StSend;
`ifdef PPE_SAT_EN
                if (sat_hit) sat_d = 1'b1;
`endif
            end
            StSend: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    dest_d      = (dest_q == 3'(FILTER_SIZE - 1)) ? 3'd0 : dest_q + 3'd1;
                    if (32'(j_q) < OutputDim - 1) begin
                        j_d     = j_q + 5'd1;
                        state_d = StSum;
                    end else if (32'(row_cnt_q) < NUM_ROWS) begin
                        j_d          = '0;
                        out_valid_d  = 1'b1;
                        out_packet_d = {4'(IMEM_ID), 4'(PE_ID), 25'd0};
                        state_d      = StReq;
                    end else begin
                        j_d     = '0;
                        state_d = StIdle;
                    end
                end
            end
            StReq: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    j_d         = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            weights_q    <= '0;
            wptr_q       <= '0;
            j_q          <= '0;
            dest_q       <= '0;
            row_cnt_q    <= '0;
            in_bits_q    <= '0;
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
`ifdef PPE_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            weights_q    <= weights_d;
            wptr_q       <= wptr_d;
            j_q          <= j_d;
            dest_q       <= dest_d;
            row_cnt_q    <= row_cnt_d;
            in_bits_q    <= in_bits_d;
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
`ifdef PPE_SAT_EN
            sat_q        <= sat_d;
`endif
        end
    end

    // The flops already clear asynchronously; in_ready also has to stay low while reset is held.
    assign in_ready   = !reset && (state_q == StIdle);
    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign busy       = (state_q != StIdle);
    assign row_cnt    = row_cnt_q;

endmodule

// File: tb/tb_ppe_sync.sv
// Bench for ppe_sync: a 14-bit and a 10-bit sum instance run in lockstep against a queue-based
// model of the packet stream, with table vectors, backpressure, row counting and mid-send reset.

module tb_ppe_sync;

    localparam int FS = 5, OD = 21, NROWS = 5, IMEM = 10, PEID = 0, SPEB = 0;
`ifdef PPE_SAT_EN
    localparam bit SatEn = 1'b1;
    localparam int Neg10 = -512, Pos10 = 511;
`else
    localparam bit SatEn = 1'b0;
    localparam int Neg10 = 384, Pos10 = -389;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready, in_ready10;
    logic [32:0] in_packet;
    logic        out_valid, out_valid10, out_ready;
    logic [32:0] out_packet, out_packet10;
    logic        busy, busy10;
    logic [3:0]  row_cnt, row_cnt10;
`ifdef PPE_SAT_EN
    logic        sat14, sat10;
`endif

    always #5 clk = ~clk;

    ppe_sync #(.SUM_WIDTH(14)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_packet(in_packet), .out_valid(out_valid), .out_ready(out_ready),
        .out_packet(out_packet), .busy(busy), .row_cnt(row_cnt)
`ifdef PPE_SAT_EN
        , .sat_flag(sat14)
`endif
    );

    ppe_sync #(.SUM_WIDTH(10)) u_dut10 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready10),
        .in_packet(in_packet), .out_valid(out_valid10), .out_ready(out_ready),
        .out_packet(out_packet10), .busy(busy10), .row_cnt(row_cnt10)
`ifdef PPE_SAT_EN
        , .sat_flag(sat10)
`endif
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: weights, pointers and the queue of packets the row must produce.
    typedef struct {
        logic [32:0] p;
        logic [32:0] p10;
        bit          is_req;
    } exp_t;

    int          mw[FS];
    int          mwptr = 0, mdest = 0, mrow = 0;
    bit          msat10 = 1'b0;
    exp_t        expq[$];
    logic [24:0] cap[$], cap10[$];

    function automatic logic [24:0] fit(input int v, input int w, input bit sat);
        int lim, r;
        lim = 1 << (w - 1);
        if (sat) begin
            if (v > lim - 1) v = lim - 1;
            if (v < -lim) v = -lim;
        end
        r = v % (2 * lim);
        if (r >= lim) r -= 2 * lim;
        if (r < -lim) r += 2 * lim;
        return 25'(r);
    endfunction

    task automatic model_send(input logic [3:0] op, input logic [24:0] data);
        byte  b;
        int   s;
        exp_t e;
        case (op)
            4'd0: begin
                for (int k = 0; k < 3; k++) begin
                    b = 8'(data >> (8 * k));
                    if (mwptr + k < FS) mw[mwptr+k] = b;
                end
                mwptr = (mwptr + 3 >= FS) ? 0 : mwptr + 3;
            end
            4'd1: begin
                mrow = (mrow < 15) ? mrow + 1 : 15;
                for (int j = 0; j < OD; j++) begin
                    s = 0;
                    for (int w = 0; w < FS; w++) if (data[j+w]) s += mw[w];
                    if (SatEn && (s > 511 || s < -512)) msat10 = 1'b1;
                    e.p      = {4'(SPEB + mdest), 4'd0, fit(s, 14, 1'b0)};
                    e.p10    = {4'(SPEB + mdest), 4'd0, fit(s, 10, SatEn)};
                    e.is_req = 1'b0;
                    expq.push_back(e);
                    mdest = (mdest + 1) % FS;
                end
                if (mrow < NROWS) begin
                    e.p      = {4'(IMEM), 4'(PEID), 25'd0};
                    e.p10    = e.p;
                    e.is_req = 1'b1;
                    expq.push_back(e);
                end
            end
            4'd15: begin
                mrow   = 0;
                msat10 = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic send_pkt(input logic [3:0] op, input logic [24:0] data);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        if (in_ready) begin
            in_valid  = 1'b1;
            in_packet = {4'd0, op, data};
            model_send(op, data);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Consume the output stream; optional random backpressure, a fixed stall window, or an
    // early stop that leaves a packet pending with out_ready low.
    task automatic drain(input int hold_after, input int hold_len, input bit rand_bp,
                         input int stop_after, output int n_xfer, output int n_req);
        logic [32:0] prev = '0;
        bit          prev_stall = 1'b0, held = 1'b0, done = 1'b0;
        int          hold = 0;
        exp_t        e;
        n_xfer = 0;
        n_req  = 0;
        cap.delete();
        cap10.delete();
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (stop_after >= 0 && n_xfer == stop_after) begin
                out_ready = 1'b0;
                return;
            end
            if (expq.size() == 0 && !busy && !out_valid) begin
                done = 1'b1;
            end else begin
                if (hold_after >= 0 && n_xfer == hold_after && !held) begin
                    held = 1'b1;
                    hold = hold_len;
                end
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                    check("in_ready_stall", in_ready, 1'b0);
                end else begin
                    out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_pkt", out_packet, prev);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        check("extra_pkt", out_packet, 33'h0);
                        check("extra_pkt_valid", 1'b1, 1'b0);
                    end else begin
                        e = expq.pop_front();
                        check("pkt", out_packet, e.p);
                        check("pkt10", out_packet10, e.p10);
                        if (e.is_req) n_req++;
                        else begin
                            cap.push_back(out_packet[24:0]);
                            cap10.push_back(out_packet10[24:0]);
                        end
                    end
                    n_xfer++;
                end
                prev_stall = out_valid && !out_ready;
                prev       = out_packet;
            end
        end
        if (!done) check("drain_timeout", {31'd0, expq.size() == 0}, 64'd2);
        check("row_cnt", row_cnt, 64'(mrow));
        check("row_cnt10", row_cnt10, 64'(mrow));
`ifdef PPE_SAT_EN
        check("sat14", sat14, 1'b0);
        check("sat10", sat10, msat10);
`endif
    endtask

    typedef struct {
        logic [24:0] w0, w1, din;
        int          s0, s4, s20, s10_0;
    } vec_t;

    vec_t        tbl[5];
    int          nx, nr, req_total, stop, d0;
    logic [24:0] e25;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{25'h030201, 25'h000504, 25'h1FFFFFF, 15, 15, 15, 15};
        tbl[1] = '{25'h030201, 25'h000504, 25'h0000001, 1, 0, 0, 1};
        tbl[2] = '{25'h030201, 25'h000504, 25'h0000010, 5, 1, 0, 5};
        tbl[3] = '{25'h808080, 25'h008080, 25'h1FFFFFF, -640, -640, -640, Neg10};
        tbl[4] = '{25'h7F7F7F, 25'h007F7F, 25'h1FFFFFF, 635, 635, 635, Pos10};
        foreach (mw[i]) mw[i] = 0;

        in_valid  = 1'b0;
        in_packet = '0;
        out_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_packet", out_packet, 33'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_row_cnt", row_cnt, 4'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        req_total = 0;
        for (int i = 0; i < 5; i++) begin
            send_pkt(4'd0, tbl[i].w0);
            send_pkt(4'd0, tbl[i].w1);
            send_pkt(4'd1, tbl[i].din);
            drain(-1, 0, 1'b0, -1, nx, nr);
            req_total += nr;
            check("sum_count", cap.size(), 21);
            if (cap.size() == 21) begin
                e25 = 25'(tbl[i].s0);    check("tbl_s0", cap[0], e25);
                e25 = 25'(tbl[i].s4);    check("tbl_s4", cap[4], e25);
                e25 = 25'(tbl[i].s20);   check("tbl_s20", cap[20], e25);
                e25 = 25'(tbl[i].s10_0); check("tbl_w10_s0", cap10[0], e25);
            end
        end
        check("req_total_5rows", req_total, 4);

        send_pkt(4'd15, 25'd0);
        drain(-1, 0, 1'b0, -1, nx, nr);
        check("row_cnt_cleared", row_cnt, 4'd0);
        send_pkt(4'd1, 25'h1FFFFFF);
        drain(-1, 0, 1'b0, -1, nx, nr);
        check("req_after_ts", nr, 1);

        send_pkt(4'd1, 25'h0ABCDEF);
        drain(7, 10, 1'b0, -1, nx, nr);
        check("hold_xfers", nx, 22);

        for (int r = 0; r < 14; r++) begin
            if (r % 3 == 0) send_pkt(4'($urandom_range(2, 14)), 25'($urandom));
            send_pkt(4'd0, 25'($urandom & 32'hFFFFFF));
            send_pkt(4'd0, 25'($urandom & 32'hFFFFFF));
            send_pkt(4'd1, 25'($urandom));
            drain(-1, 0, 1'b1, -1, nx, nr);
            check("rand_sum_count", cap.size(), 21);
        end

        d0   = mdest;
        stop = ((d0 + 7) % FS == 0) ? 8 : 7;
        send_pkt(4'd1, 25'h1FFFFFF);
        drain(-1, 0, 1'b1, stop, nx, nr);
        repeat (2) @(negedge clk);
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_addr", out_packet[32:29], 4'((d0 + stop) % FS));
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_packet", out_packet, 33'h0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_row_cnt", row_cnt, 4'd0);
        foreach (mw[i]) mw[i] = 0;
        mwptr  = 0;
        mdest  = 0;
        mrow   = 0;
        msat10 = 1'b0;
        expq.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_release_in_ready", in_ready, 1'b1);
        send_pkt(4'd0, tbl[0].w0);
        send_pkt(4'd0, tbl[0].w1);
        send_pkt(4'd1, 25'h1FFFFFF);
        drain(-1, 0, 1'b0, -1, nx, nr);
        check("post_rst_xfers", nx, 22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
